// File: rtl/io_port_pkg.sv
// ---------------------------------------------------------------------------
// io_port_pkg
// Shared definitions for the core's I/O port logic: the default port word
// width, the default output queue depth, and the state encoding used by the
// output queue's device-side control FSM.
// ---------------------------------------------------------------------------
package io_port_pkg;

    localparam int PORT_DATA_W = 16;
    localparam int OUT_Q_DEPTH = 4;

    // Q_IDLE: nothing queued, nothing presented to the device.
    // Q_SEND: at least one word queued, head word presented to the device.
    typedef enum logic {
        Q_IDLE = 1'b0,
        Q_SEND = 1'b1
    } q_state_t;

endpackage : io_port_pkg

// File: rtl/port_fifo_mem.sv
// ---------------------------------------------------------------------------
// port_fifo_mem
// DEPTH x DATA_W register array backing the output port queue.
// One synchronous write port and one asynchronous (combinational) read port.
// The array is deliberately not reset: the queue's pointers and count decide
// which entries are meaningful, so stale contents are never observed.
//
// Ports:
//   i_clk      in   1        core clock, rising edge
//   i_wr_en    in   1        write enable
//   i_wr_addr  in   ADDR_W   write address
//   i_wr_data  in   DATA_W   write data
//   i_rd_addr  in   ADDR_W   read address
//   o_rd_data  out  DATA_W   mem[i_rd_addr], combinational
// ---------------------------------------------------------------------------
module port_fifo_mem #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = mem[i_rd_addr];

endmodule : port_fifo_mem

// File: rtl/out_port_queue.sv
// ---------------------------------------------------------------------------
// out_port_queue
// Buffers values written by OUT instructions in the execute-memory stage and
// drains them to the external device over a valid/ready handshake. When the
// queue is full, an OUT instruction raises o_stall so the pipeline holds it
// until space frees up. The last word accepted by the device is kept in
// o_last_value for readback and debug.
//
// Ports:
//   i_clk               in   1         core clock, rising edge
//   i_rst_n             in   1         asynchronous active-low reset
//   i_out_port_signal   in   1         OUT instruction present this cycle
//   i_data_to_out_port  in   DATA_W    value the OUT instruction writes
//   o_stall             out  1         OUT requested while full
//   o_port_valid        out  1         head entry presented to the device
//   o_port_data         out  DATA_W    head entry, 0 when empty
//   i_port_ready        in   1         device accepts o_port_data this cycle
//   o_last_value        out  DATA_W    last word accepted by the device
//   o_count             out  ADDR_W+1  occupied entries
//   o_full              out  1         count == DEPTH
//   o_empty             out  1         count == 0
// ---------------------------------------------------------------------------
module out_port_queue
    import io_port_pkg::*;
#(
    parameter  int DATA_W = PORT_DATA_W,
    parameter  int DEPTH  = OUT_Q_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_out_port_signal,
    input  logic [DATA_W-1:0] i_data_to_out_port,
    output logic              o_stall,
    output logic              o_port_valid,
    output logic [DATA_W-1:0] o_port_data,
    input  logic              i_port_ready,
    output logic [DATA_W-1:0] o_last_value,
    output logic [ADDR_W:0]   o_count,
    output logic              o_full,
    output logic              o_empty
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_COUNT  = (ADDR_W+1)'(1);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic [DATA_W-1:0] head_data;
    logic              push;
    logic              pop;
    q_state_t          state;
    q_state_t          state_next;

    // Flags come from the registered count, so a full-queue write cannot be
    // admitted in the same cycle a pop frees a slot; it is taken next cycle.
    assign o_full  = (count == FULL_COUNT);
    assign o_empty = (count == '0);
    assign o_count = count;

    assign push    = i_out_port_signal && !o_full;
    assign pop     = o_port_valid && i_port_ready;
    assign o_stall = i_out_port_signal && o_full;

    assign o_port_valid = (state == Q_SEND);
    assign o_port_data  = o_port_valid ? head_data : '0;

    port_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .i_clk     (i_clk),
        .i_wr_en   (push),
        .i_wr_addr (wr_ptr),
        .i_wr_data (i_data_to_out_port),
        .i_rd_addr (rd_ptr),
        .o_rd_data (head_data)
    );

    // Pointers and occupancy. Pointers wrap naturally at DEPTH since DEPTH is
    // a power of two; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + ONE_COUNT;
                2'b01:   count <= count - ONE_COUNT;
                default: count <= count;
            endcase
        end
    end

    // Capture the word the device just accepted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_last_value <= '0;
        end else if (pop) begin
            o_last_value <= o_port_data;
        end
    end

    // Device-side state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= Q_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: go to SEND on the first push into an empty queue; fall back
    // to IDLE only when the last entry leaves without a replacement arriving.
    always_comb begin
        state_next = state;
        case (state)
            Q_IDLE: begin
                if (push) begin
                    state_next = Q_SEND;
                end
            end
            Q_SEND: begin
                if (pop && !push && (count == ONE_COUNT)) begin
                    state_next = Q_IDLE;
                end
            end
            default: state_next = Q_IDLE;
        endcase
    end

endmodule : out_port_queue
